// File: rtl/instr_mem_ctrl_if.sv
// Fetch/load bus between the core and the instruction memory controller.
// The parity inject/report signals exist only when IMEM_PARITY_EN is defined.
interface instr_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              FetchReady;
    logic              FetchValid;
    logic [DATA_W-1:0] FetchData;
    logic              FetchErr;
    logic              Stall;
    logic              LoadWe;
    logic [ADDR_W-1:0] LoadAddr;
    logic [DATA_W-1:0] LoadData;
    logic              InitBusy;
`ifdef IMEM_PARITY_EN
    logic              LoadPerrInject;
    logic              FetchPerr;

    modport master (
        output FetchReq, FetchAddr, Stall, LoadWe, LoadAddr, LoadData, LoadPerrInject,
        input  FetchReady, FetchValid, FetchData, FetchErr, InitBusy, FetchPerr
    );

    modport slave (
        input  FetchReq, FetchAddr, Stall, LoadWe, LoadAddr, LoadData, LoadPerrInject,
        output FetchReady, FetchValid, FetchData, FetchErr, InitBusy, FetchPerr
    );
`else
    modport master (
        output FetchReq, FetchAddr, Stall, LoadWe, LoadAddr, LoadData,
        input  FetchReady, FetchValid, FetchData, FetchErr, InitBusy
    );

    modport slave (
        input  FetchReq, FetchAddr, Stall, LoadWe, LoadAddr, LoadData,
        output FetchReady, FetchValid, FetchData, FetchErr, InitBusy
    );
`endif
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: sequential post-reset clear, 1-cycle read-first fetch port
// with stall, and a program-load port. Optional per-word parity under IMEM_PARITY_EN.
module instr_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    instr_mem_ctrl_if.slave imem
);
    localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef IMEM_PARITY_EN
    function automatic logic parity_even(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    state_t            state_r;
    logic [AW-1:0]     cnt_r;
    logic              init_busy_r;
    logic              fetch_valid_r;
    logic              fetch_err_r;
    logic [DATA_W-1:0] fetch_data_r;
    logic [MEM_W-1:0]  mem_r [DEPTH];

    logic              fetch_ready_s;
    logic              accept_s;
    logic              fetch_bad_s;
    logic [AW-1:0]     fetch_idx_s;
    logic [MEM_W-1:0]  rd_word_s;
    logic              load_in_range_s;
    logic [AW-1:0]     load_idx_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_wa_s;
    logic [MEM_W-1:0]  mem_wd_s;
`ifdef IMEM_PARITY_EN
    logic              rd_perr_s;
    logic              fetch_perr_r;
`endif

    // Fetch-side decode: handshake, address checks and the addressed word (pre-write value).
    always_comb begin
        fetch_ready_s   = (state_r == ST_RUN) && !(fetch_valid_r && imem.Stall);
        accept_s        = imem.FetchReq && fetch_ready_s;
        fetch_idx_s     = imem.FetchAddr[AW+1:2];
        fetch_bad_s     = (imem.FetchAddr[1:0] != 2'b00)
                       || ((imem.FetchAddr >> (AW + 2)) != {ADDR_W{1'b0}});
        rd_word_s       = mem_r[fetch_idx_s];
        load_idx_s      = imem.LoadAddr[AW+1:2];
        load_in_range_s = ((imem.LoadAddr >> (AW + 2)) == {ADDR_W{1'b0}});
`ifdef IMEM_PARITY_EN
        rd_perr_s       = parity_even(rd_word_s[DATA_W-1:0]) != rd_word_s[DATA_W];
`endif
    end

    // Memory write port: the clear sweep owns it in INIT, the load port in RUN.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = cnt_r;
        mem_wd_s = {MEM_W{1'b0}};
        case (state_r)
            ST_INIT: begin
                mem_we_s = 1'b1;
                mem_wa_s = cnt_r;
                mem_wd_s = {MEM_W{1'b0}};
            end
            ST_RUN: begin
                mem_we_s = imem.LoadWe && load_in_range_s;
                mem_wa_s = load_idx_s;
`ifdef IMEM_PARITY_EN
                mem_wd_s = {parity_even(imem.LoadData) ^ imem.LoadPerrInject, imem.LoadData};
`else
                mem_wd_s = imem.LoadData;
`endif
            end
            default: begin
                mem_we_s = 1'b0;
                mem_wa_s = cnt_r;
                mem_wd_s = {MEM_W{1'b0}};
            end
        endcase
    end

    // Storage array; deliberately outside the reset domain so reset never touches contents.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Controller FSM with registered fetch outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r       <= ST_INIT;
            cnt_r         <= {AW{1'b0}};
            init_busy_r   <= 1'b1;
            fetch_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
            fetch_data_r  <= {DATA_W{1'b0}};
`ifdef IMEM_PARITY_EN
            fetch_perr_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r         <= cnt_r + CNT_ONE;
                    fetch_valid_r <= 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_RUN;
                        init_busy_r <= 1'b0;
                    end else begin
                        state_r     <= ST_INIT;
                        init_busy_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_busy_r <= 1'b0;
                    if (accept_s) begin
                        fetch_valid_r <= 1'b1;
                        fetch_err_r   <= fetch_bad_s;
                        fetch_data_r  <= fetch_bad_s ? {DATA_W{1'b0}} : rd_word_s[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
                        fetch_perr_r  <= fetch_bad_s ? 1'b0 : rd_perr_s;
`endif
                    end else if (fetch_valid_r && imem.Stall) begin
                        fetch_valid_r <= fetch_valid_r;
                    end else begin
                        // Data and error flags keep their last value once valid drops.
                        fetch_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_INIT;
                    cnt_r         <= {AW{1'b0}};
                    init_busy_r   <= 1'b1;
                    fetch_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem.FetchReady = fetch_ready_s;
    assign imem.FetchValid = fetch_valid_r;
    assign imem.FetchData  = fetch_data_r;
    assign imem.FetchErr   = fetch_err_r;
    assign imem.InitBusy   = init_busy_r;
`ifdef IMEM_PARITY_EN
    assign imem.FetchPerr  = fetch_perr_r;
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomised + directed bench for instr_mem_ctrl against a transaction-level memory model.
// Parity checks are included when IMEM_PARITY_EN is defined.
module tb_instr_mem_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * 4);

    logic CLK = 1'b0;
    logic RESET_N;

    instr_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .imem    (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Reference model: memory image plus the expected registered fetch outputs.
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_par [DEPTH];
    bit                m_run;
    int                m_init_left;
    logic              m_valid;
    logic              m_err;
    logic              m_perr;
    logic [DATA_W-1:0] m_data;
    logic              cur_inj;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_run       = 1'b0;
        m_init_left = DEPTH;
        m_valid     = 1'b0;
        m_err       = 1'b0;
        m_perr      = 1'b0;
        m_data      = '0;
    endtask

    task automatic drive(input logic req, input logic [ADDR_W-1:0] faddr, input logic stall,
                         input logic we, input logic [ADDR_W-1:0] laddr,
                         input logic [DATA_W-1:0] ldata, input logic inj);
        bus.FetchReq  = req;
        bus.FetchAddr = faddr;
        bus.Stall     = stall;
        bus.LoadWe    = we;
        bus.LoadAddr  = laddr;
        bus.LoadData  = ldata;
        cur_inj       = inj;
`ifdef IMEM_PARITY_EN
        bus.LoadPerrInject = inj;
`endif
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_outputs();
        check_val("FetchValid", {63'b0, bus.FetchValid}, {63'b0, m_valid});
        check_val("FetchData", {32'b0, bus.FetchData}, {32'b0, m_data});
        check_val("FetchErr", {63'b0, bus.FetchErr}, {63'b0, m_err});
        check_val("InitBusy", {63'b0, bus.InitBusy}, {63'b0, !m_run});
`ifdef IMEM_PARITY_EN
        check_val("FetchPerr", {63'b0, bus.FetchPerr}, {63'b0, m_perr});
`endif
    endtask

    // One clock: inputs already applied at the preceding falling edge.
    task automatic step();
        logic exp_ready;
        logic bad;
        int   idx;
        #1;
        exp_ready = m_run && !(m_valid && bus.Stall);
        check_val("FetchReady", {63'b0, bus.FetchReady}, {63'b0, exp_ready});
        if (m_run) begin
            if (bus.FetchReq && exp_ready) begin
                bad     = (bus.FetchAddr % 4 != 0) || (bus.FetchAddr >= MEM_BYTES);
                m_valid = 1'b1;
                m_err   = bad;
                if (bad) begin
                    m_data = '0;
                    m_perr = 1'b0;
                end else begin
                    idx    = int'(bus.FetchAddr / 4);
                    m_data = m_mem[idx];
                    m_perr = (^m_mem[idx]) != m_par[idx];
                end
            end else if (!(m_valid && bus.Stall)) begin
                m_valid = 1'b0;
            end
            // Load lands after the read: a same-word fetch sees the old contents.
            if (bus.LoadWe && bus.LoadAddr < MEM_BYTES) begin
                idx        = int'(bus.LoadAddr / 4);
                m_mem[idx] = bus.LoadData;
                m_par[idx] = (^bus.LoadData) ^ cur_inj;
            end
        end else begin
            m_init_left--;
            if (m_init_left == 0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    m_mem[k] = '0;
                    m_par[k] = 1'b0;
                end
                m_run = 1'b1;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic do_reset(input int hold_cycles);
        RESET_N = 1'b0;
        m_reset();
        #1;
        check_val("rst FetchValid", {63'b0, bus.FetchValid}, 64'd0);
        check_val("rst FetchData", {32'b0, bus.FetchData}, 64'd0);
        check_val("rst FetchErr", {63'b0, bus.FetchErr}, 64'd0);
        check_val("rst InitBusy", {63'b0, bus.InitBusy}, 64'd1);
        check_val("rst FetchReady", {63'b0, bus.FetchReady}, 64'd0);
        repeat (hold_cycles) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // Runs the clear phase with loads attempted (must be ignored) and counts busy cycles.
    task automatic run_init();
        int busy_cycles = 0;
        for (int g = 0; g < 200; g++) begin
            if (!bus.InitBusy) break;
            busy_cycles++;
            drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0);
            step();
        end
        idle();
        check_val("init busy cycles", 64'(busy_cycles), 64'(DEPTH));
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 7) return ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 7) return ADDR_W'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else if (r == 8) return MEM_BYTES + ADDR_W'($urandom_range(0, 255));
        else return ADDR_W'($urandom);
    endfunction

    initial begin
        RESET_N = 1'b1;
        idle();
        #2;
        do_reset(3);
        run_init();

        // Cleared memory reads back zero, including the last word.
        drive(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        drive(1'b1, 32'hFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();

        // Program load then back-to-back fetches.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'h0000_0013, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 32'h0050_0093, 1'b0); step();
        drive(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        check_val("b2b word0", {32'b0, bus.FetchData}, 64'h0000_0013);
        drive(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        check_val("b2b word1", {32'b0, bus.FetchData}, 64'h0050_0093);
        idle(); step();

        // Error fetches and a dropped out-of-range load, then sweep the whole memory.
        drive(1'b1, 32'h06, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        check_val("misaligned err", {63'b0, bus.FetchErr}, 64'd1);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 32'hA5A5_A5A5, 1'b0); step();
        check_val("oor err", {63'b0, bus.FetchErr}, 64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, ADDR_W'(k * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            step();
        end

        // Stall holds a valid word for three cycles, then the pipe moves on.
        drive(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            step();
            check_val("stall hold", {32'b0, bus.FetchData}, 64'h0050_0093);
        end
        drive(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();

        // Same-cycle load and fetch of one word: read-first.
        drive(1'b1, 32'h08, 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0); step();
        check_val("read-first old", {32'b0, bus.FetchData}, 64'h0);
        drive(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        check_val("read-first new", {32'b0, bus.FetchData}, 64'hDEAD_BEEF);

        // Reset while a word is valid: memory must be re-cleared.
        do_reset(2);
        run_init();
        drive(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
        check_val("recleared word2", {32'b0, bus.FetchData}, 64'h0);

        // Parity injection (only observable with parity enabled).
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b1); step();
        drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h14, 32'h0000_0007, 1'b0); step();
        drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, rand_addr(), DATA_W'($urandom),
                  $urandom_range(0, 7) == 0);
            step();
        end
        idle(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory controller for the RISC-V core. It generalises the fixed 64x32 instruction memory:
- configurable width and depth
- byte-address fetch port with a req/ready/valid handshake and pipeline stall
- separate program-load write port
- sequential post-reset clear FSM instead of a single-cycle clear

It sits between the fetch stage (PC) and the decode stage.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 64, number of words (power of two, >=4)
ADDR_W, 32, byte-address width of fetch and load ports
(internal: AW = $clog2(DEPTH); word index = addr[AW+1:2])

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
FetchReq  in  1  fetch request
FetchAddr  in  ADDR_W  byte address (PC)
FetchReady  out  1  controller can accept a fetch this cycle
FetchValid  out  1  FetchData/FetchErr valid
FetchData  out  DATA_W  instruction word
FetchErr  out  1  misaligned or out-of-range fetch
Stall  in  1  downstream stage holds current output
LoadWe  in  1  program-load write strobe
LoadAddr  in  ADDR_W  byte address for load
LoadData  in  DATA_W  word to write
InitBusy  out  1  post-reset clear in progress

Behaviour:
- States: INIT, RUN.
- RESET_N low (asynchronous):
  - state=INIT, clear counter=0
  - FetchValid=0, FetchData=0, FetchErr=0, InitBusy=1
  - Memory contents are not touched by the reset itself.
- INIT:
  - Each cycle writes 0 to Memory[cnt], then cnt++.
  - After the write of word DEPTH-1, go to RUN, InitBusy=0.
  - Exactly DEPTH cycles from reset release to the first cycle with FetchReady=1.
  - LoadWe is ignored and FetchReady=0 throughout.
- FetchReady = (state==RUN) && !(FetchValid && Stall). Combinational.
- Accept = FetchReq && FetchReady. Latency is 1 cycle: on the next edge FetchValid=1.
  - Normal fetch: FetchData=Memory[idx], FetchErr=0.
  - Error: FetchErr=1 and FetchData=0 if FetchAddr[1:0]!=0 or FetchAddr >= DEPTH*4 (upper bits nonzero).
- FetchValid && Stall: FetchValid, FetchData and FetchErr hold unchanged; no new accept.
- No accept and no stall: FetchValid goes to 0 next edge; FetchData and FetchErr hold their last value.
- Back-to-back accepts give one valid word per cycle (full throughput).
- Load, RUN only: LoadWe writes LoadData to Memory[LoadAddr[AW+1:2]].
  - LoadAddr[1:0] is ignored.
  - Out-of-range LoadAddr (>= DEPTH*4): write dropped.
- Same-cycle load and fetch to the same word: read-first. The fetch returns the old word; the new word is visible from the following accept.
- Reset asserted mid-operation: immediate return to INIT. Any pending valid is dropped and the whole memory is re-cleared.

Optional Feature:
IMEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed on every write (INIT writes parity 0).
  - Adds input LoadPerrInject (1 bit): when high with LoadWe, the stored parity bit is inverted.
  - Adds output FetchPerr: registered alongside FetchValid; 1 when the recomputed parity of the read word mismatches the stored bit. It holds under stall, resets to 0, and is forced 0 when FetchErr=1.
- Undefined: no parity storage, no LoadPerrInject and no FetchPerr ports; behaviour otherwise identical.

Test Plan:
1. Reset release -> InitBusy=1 for exactly 64 cycles, FetchReady=0. Then fetch 0x00, 0x04, 0xFC -> FetchValid next cycle, FetchData=0x00000000 each.
2. Load 0x00000013 @0x00 and 0x00500093 @0x04; fetch 0x00 then 0x04 back-to-back -> valid on two consecutive cycles, data 0x00000013 then 0x00500093.
3. Fetch 0x06 -> FetchErr=1, FetchData=0. Fetch 0x100 (DEPTH=64) -> FetchErr=1. Load to 0x100 -> no memory word changes.
4. Valid word 0x00500093 with Stall=1 for 3 cycles -> FetchReady=0 and outputs held for all 3 cycles. Stall low -> next accept proceeds.
5. Same cycle: load 0xDEADBEEF @0x08 and fetch 0x08 (old 0x0) -> returns 0x0; the next fetch of 0x08 returns 0xDEADBEEF.
6. RESET_N pulsed low while FetchValid=1 -> FetchValid=0 immediately, InitBusy=1. After 64 cycles a fetch of 0x00 returns 0. With IMEM_PARITY_EN: load with LoadPerrInject=1 then fetch -> FetchPerr=1.
